interval_timer_ctrl: RTL

Programmable interval timer and parameter store serving the traffic-light sequencing FSM. It holds the three interval values (base, extended, yellow) and accepts run-time reprogramming writes. It counts down the interval selected by `timeParameter` on each `startTimer` request and returns a one-cycle `expired` pulse. After any accepted reprogramming write it issues `reprogram` so the FSM restarts in main-green.

---
 rtl/interval_timer_ctrl_if.sv | 31 +++
 rtl/interval_timer_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/interval_timer_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : interval_timer_ctrl_if                                    |
// | Brief    : Start/expire handshake and reprogramming bus of the timer |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface interval_timer_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             startTimer;
  logic [1:0]       timeParameter;
  logic             prog_load;
  logic [1:0]       prog_sel;
  logic [CNT_W-1:0] prog_value;
  logic             expired;
  logic             reprogram;
  logic             busy;
  logic [CNT_W-1:0] remaining;
  logic             tick;

  modport master (
    output startTimer, timeParameter, prog_load, prog_sel, prog_value,
    input  expired, reprogram, busy, remaining, tick
  );

  modport slave (
    input  startTimer, timeParameter, prog_load, prog_sel, prog_value,
    output expired, reprogram, busy, remaining, tick
  );
endinterface
`default_nettype wire

// File: rtl/interval_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : interval_timer_ctrl                                       |
// | Brief    : Interval timer + parameter store for the light sequencer. |
// |            Run-time reprogramming enabled by macro TIMER_PROG_EN.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module interval_timer_ctrl #(
  parameter int PRESCALE = 50_000_000,
  parameter int CNT_W    = 4,
  parameter int BASE_DEF = 6,
  parameter int EXT_DEF  = 3,
  parameter int YEL_DEF  = 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  interval_timer_ctrl_if.slave  tmr
);

  localparam int              c_PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0] c_PMAX  = c_PW'(PRESCALE - 1);
  localparam logic [1:0]      c_IDLE  = 2'd0;
  localparam logic [1:0]      c_COUNT = 2'd1;
  localparam logic [1:0]      c_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [c_PW-1:0]  r_presc;
  logic [c_PW-1:0]  w_presc_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             r_busy;
  logic             r_expired;
  logic             r_tick;
  logic             w_busy_nxt;
  logic             w_expired_nxt;
  logic             w_tick_nxt;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_ext;
  logic [CNT_W-1:0] w_yel;
  logic [CNT_W-1:0] w_sel_val;
  logic [CNT_W-1:0] w_load_val;
  logic             w_tick_now;

`ifdef TIMER_PROG_EN
  logic [CNT_W-1:0] r_base;
  logic [CNT_W-1:0] r_ext;
  logic [CNT_W-1:0] r_yel;
  logic             r_reprogram;
  logic             w_accept;

  assign w_accept = tmr.prog_load && (tmr.prog_sel != 2'b11);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_base      <= CNT_W'(BASE_DEF);
      r_ext       <= CNT_W'(EXT_DEF);
      r_yel       <= CNT_W'(YEL_DEF);
      r_reprogram <= 1'b0;
    end else begin
      r_reprogram <= w_accept;
      if (w_accept) begin
        case (tmr.prog_sel)
          2'b00:   r_base <= tmr.prog_value;
          2'b01:   r_ext  <= tmr.prog_value;
          default: r_yel  <= tmr.prog_value;
        endcase
      end
    end
  end

  assign w_base        = r_base;
  assign w_ext         = r_ext;
  assign w_yel         = r_yel;
  assign tmr.reprogram = r_reprogram;
`else
  assign w_base        = CNT_W'(BASE_DEF);
  assign w_ext         = CNT_W'(EXT_DEF);
  assign w_yel         = CNT_W'(YEL_DEF);
  assign tmr.reprogram = 1'b0;
`endif

  // Reads the registers before any same-cycle write lands.
  always_comb begin
    case (tmr.timeParameter)
      2'b00:   w_sel_val = w_base;
      2'b01:   w_sel_val = w_ext;
      default: w_sel_val = w_yel;
    endcase
  end

  assign w_load_val = (w_sel_val == '0) ? CNT_W'(1) : w_sel_val;
  assign w_tick_now = (r_state == c_COUNT) && (r_presc == c_PMAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A start in any state restarts the countdown and drops a pending expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (tmr.startTimer) w_state_nxt = c_COUNT;
      end
      c_COUNT: begin
        if (tmr.startTimer)
          w_state_nxt = c_COUNT;
        else if (w_tick_now && (r_remaining == CNT_W'(1)))
          w_state_nxt = c_DONE;
      end
      c_DONE: begin
        w_state_nxt = tmr.startTimer ? c_COUNT : c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_presc_nxt = '0;
    w_rem_nxt   = r_remaining;
    if (tmr.startTimer) begin
      w_rem_nxt = w_load_val;
    end else if (r_state == c_COUNT) begin
      if (w_tick_now) begin
        w_rem_nxt = r_remaining - CNT_W'(1);
      end else begin
        w_presc_nxt = r_presc + c_PW'(1);
      end
    end
  end

  // Outputs are computed from next state so they can be registered.
  always_comb begin
    w_busy_nxt    = (w_state_nxt != c_IDLE);
    w_expired_nxt = (w_state_nxt == c_DONE);
    w_tick_nxt    = (w_state_nxt == c_COUNT) && (w_presc_nxt == c_PMAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_presc     <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_expired   <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_presc     <= w_presc_nxt;
      r_remaining <= w_rem_nxt;
      r_busy      <= w_busy_nxt;
      r_expired   <= w_expired_nxt;
      r_tick      <= w_tick_nxt;
    end
  end

  assign tmr.expired   = r_expired;
  assign tmr.busy      = r_busy;
  assign tmr.remaining = r_remaining;
  assign tmr.tick      = r_tick;

endmodule
`default_nettype wire
